// File: rtl/dispara_tiro_pkg.sv
// Shared definitions for the shot-launch stage: FSM state codes, heading opcodes, default width.
// The optional fire-rate limit is enabled with DISPARA_TIRO_COOLDOWN_EN.
package dispara_tiro_pkg;

  typedef enum logic [4:0] {
    INICIAL = 5'd0,
    ESPERA  = 5'd1,
    BUSCA   = 5'd2,
    ESCREVE = 5'd3,
    FIM     = 5'd4
  } estado_t;

  // Heading encoding shared with the shot-movement stage
  localparam logic [1:0] OP_CIMA     = 2'd0;
  localparam logic [1:0] OP_DIREITA  = 2'd1;
  localparam logic [1:0] OP_BAIXO    = 2'd2;
  localparam logic [1:0] OP_ESQUERDA = 2'd3;

  localparam int COORD_W_PADRAO = 5;

endpackage

// File: rtl/dispara_tiro_contador_cooldown.sv
// Cooldown counter: loads MAX, decrements on each frame tick, saturates at 0.
// Instantiated by dispara_tiro only when DISPARA_TIRO_COOLDOWN_EN is defined.
module contador_cooldown #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic carrega,
  input  logic tick,
  output logic zero
);

  logic [W-1:0] cont;

  // A load takes priority over a coincident tick
  always_ff @(posedge clock) begin
    if (!reset)
      cont <= '0;
    else if (carrega)
      cont <= W'(MAX);
    else if (tick && cont != '0)
      cont <= cont - W'(1);
  end

  assign zero = (cont == '0);

endmodule

// File: rtl/dispara_tiro.sv
// Shot-launch stage: on a fire request, writes a shot into the lowest free slot of shot memory.
// Define DISPARA_TIRO_COOLDOWN_EN to enable the frame-based fire-rate cooldown.
module dispara_tiro
  import dispara_tiro_pkg::*;
#(
  parameter int N_TIROS  = 4,
  parameter int COORD_W  = COORD_W_PADRAO,
  parameter int COOLDOWN = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic                       tick_frame,
  input  logic [COORD_W-1:0]         nave_x,
  input  logic [COORD_W-1:0]         nave_y,
  input  logic [1:0]                 nave_opcode,
  input  logic                       mem_loaded_in,
  output logic [$clog2(N_TIROS)-1:0] mem_endereco,
  output logic                       mem_escreve,
  output logic [COORD_W-1:0]         mem_x,
  output logic [COORD_W-1:0]         mem_y,
  output logic [1:0]                 mem_opcode,
  output logic                       mem_loaded,
  output logic                       disparo_concluido,
  output logic                       disparo_aceito,
  output logic [4:0]                 db_estado
);

  localparam int END_W = $clog2(N_TIROS);

  estado_t            estado, proximo;
  logic [END_W-1:0]   contador;
  logic [COORD_W-1:0] x_reg, y_reg;
  logic [1:0]         op_reg;
  logic               aceito_reg;
  logic               em_cooldown;
  logic               ultimo;

  assign ultimo = (contador == END_W'(N_TIROS - 1));

`ifdef DISPARA_TIRO_COOLDOWN_EN
  logic cd_zero;

  contador_cooldown #(.MAX(COOLDOWN)) u_cooldown (
    .clock   (clock),
    .reset   (reset),
    .carrega (estado == ESCREVE),
    .tick    (tick_frame),
    .zero    (cd_zero)
  );

  assign em_cooldown = !cd_zero;
`else
  logic unused_cfg;

  assign unused_cfg  = tick_frame ^ (COOLDOWN > 0);
  assign em_cooldown = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset)
      estado <= INICIAL;
    else
      estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL: proximo = ESPERA;
      ESPERA:  if (iniciar) proximo = em_cooldown ? FIM : BUSCA;
      BUSCA: begin
        if (!mem_loaded_in)
          proximo = ESCREVE;
        else if (ultimo)
          proximo = FIM;
      end
      ESCREVE: proximo = FIM;
      FIM:     proximo = ESPERA;
      default: proximo = INICIAL;
    endcase
  end

  // Ship snapshot, slot counter and accept flag; the counter holds once a free slot is found
  always_ff @(posedge clock) begin
    if (!reset) begin
      contador   <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      op_reg     <= '0;
      aceito_reg <= 1'b0;
    end else begin
      case (estado)
        ESPERA: begin
          if (iniciar) begin
            x_reg      <= nave_x;
            y_reg      <= nave_y;
            op_reg     <= nave_opcode;
            contador   <= '0;
            aceito_reg <= 1'b0;
          end
        end
        BUSCA:   if (mem_loaded_in && !ultimo) contador <= contador + END_W'(1);
        ESCREVE: aceito_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_endereco      = contador;
  assign mem_escreve       = (estado == ESCREVE);
  assign mem_loaded        = (estado == ESCREVE);
  assign mem_x             = x_reg;
  assign mem_y             = y_reg;
  assign mem_opcode        = op_reg;
  assign disparo_concluido = (estado == FIM);
  assign disparo_aceito    = (estado == FIM) && aceito_reg;
  assign db_estado         = estado;

endmodule
